// File: rtl/ps2_kb_fifo.sv
// PS/2 keyboard receiver: input synchronisers, KB_CLK glitch filter, frame FSM with timeout,
// scan-code FIFO and CPU read port. Build option PS2_PARITY_DROP_EN discards bad-parity frames.
module ps2_kb_fifo #(
    parameter int FIFO_AW    = 3,
    parameter int FILTER_LEN = 4,
    parameter int TIMEOUT    = 2048
) (
    input  logic       CLK2,
    input  logic       RST,
    input  logic       KB_CLK,
    input  logic       KB_DATA,
    input  logic       CS,
    input  logic       RD,
    input  logic       A0,
    output logic [7:0] DOUT,
    output logic       DOE,
    output logic       INT
);

    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int CW    = FIFO_AW + 1;
    localparam int FCW   = $clog2(FILTER_LEN + 1);
    localparam int TOW   = $clog2(TIMEOUT + 1);
`ifdef PS2_PARITY_DROP_EN
    localparam bit DROP_BAD = 1'b1;
`else
    localparam bit DROP_BAD = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic [1:0]     kb_clk_sync_q, kb_data_sync_q, cs_sync_q, rd_sync_q;
    logic           filt_q, filt_prev_q;
    logic [FCW-1:0] fcnt_q;
    logic           kb_clk_s, kb_data_s, fall;

    assign kb_clk_s  = kb_clk_sync_q[1];
    assign kb_data_s = kb_data_sync_q[1];
    assign fall      = filt_prev_q & ~filt_q;

    // NOTE: RST is sampled on CLK2 like any other input, so it stays out of the sensitivity list.
    always_ff @(posedge CLK2) begin
        if (!RST) begin
            kb_clk_sync_q  <= 2'b11;
            kb_data_sync_q <= 2'b11;
            cs_sync_q      <= 2'b11;
            rd_sync_q      <= 2'b11;
            filt_q         <= 1'b1;
            filt_prev_q    <= 1'b1;
            fcnt_q         <= '0;
        end else begin
            kb_clk_sync_q  <= {kb_clk_sync_q[0], KB_CLK};
            kb_data_sync_q <= {kb_data_sync_q[0], KB_DATA};
            cs_sync_q      <= {cs_sync_q[0], CS};
            rd_sync_q      <= {rd_sync_q[0], RD};
            filt_prev_q    <= filt_q;
            // The filtered clock flips only after FILTER_LEN consecutive opposite samples.
            if (kb_clk_s != filt_q) begin
                if (fcnt_q == FCW'(FILTER_LEN - 1)) begin
                    filt_q <= kb_clk_s;
                    fcnt_q <= '0;
                end else begin
                    fcnt_q <= fcnt_q + FCW'(1);
                end
            end else begin
                fcnt_q <= '0;
            end
        end
    end

    state_t         state_q;
    logic [2:0]     bitcnt_q;
    logic [7:0]     sr_q;
    logic           par_ok_q;
    logic [TOW-1:0] tmo_q;
    logic           push_q, perr_set_q, ferr_set_q;

    always_ff @(posedge CLK2) begin
        if (!RST) begin
            state_q    <= S_IDLE;
            bitcnt_q   <= '0;
            sr_q       <= '0;
            par_ok_q   <= 1'b0;
            tmo_q      <= '0;
            push_q     <= 1'b0;
            perr_set_q <= 1'b0;
            ferr_set_q <= 1'b0;
        end else begin
            push_q     <= 1'b0;
            perr_set_q <= 1'b0;
            ferr_set_q <= 1'b0;
            if (fall || state_q == S_IDLE) tmo_q <= '0;
            else                           tmo_q <= tmo_q + TOW'(1);

            if (fall) begin
                case (state_q)
                    S_IDLE: begin
                        if (!kb_data_s) begin
                            state_q  <= S_DATA;
                            bitcnt_q <= '0;
                        end
                    end
                    S_DATA: begin
                        sr_q     <= {kb_data_s, sr_q[7:1]};
                        bitcnt_q <= bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) state_q <= S_PARITY;
                    end
                    S_PARITY: begin
                        par_ok_q <= ^{sr_q, kb_data_s};
                        state_q  <= S_STOP;
                    end
                    S_STOP: begin
                        if (kb_data_s) begin
                            push_q     <= par_ok_q | ~DROP_BAD;
                            perr_set_q <= ~par_ok_q;
                        end else begin
                            ferr_set_q <= 1'b1;
                        end
                        state_q <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end else if (state_q != S_IDLE && tmo_q == TOW'(TIMEOUT - 1)) begin
                state_q <= S_IDLE;
            end
        end
    end

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]      count_q, count_d;
    logic               acc, acc_q, a0_q;
    logic               ovr_q, perr_q, ferr_q, int_q;
    logic               nempty, full, acc_end, pop, clr_req, wr, ovr_set;
    logic [7:0]         status, dout_mux;

    assign acc     = ~cs_sync_q[1] & ~rd_sync_q[1];
    assign acc_end = acc_q & ~acc;
    assign nempty  = (count_q != '0);
    assign full    = (count_q == CW'(DEPTH));
    assign pop     = acc_end & ~a0_q & nempty;
    assign clr_req = acc_end & a0_q;
    assign wr      = push_q & (~full | pop);
    assign ovr_set = push_q & full & ~pop;
    assign status  = {3'b000, ferr_q, perr_q, ovr_q, full, nempty};

    always_comb begin
        count_d = count_q;
        if (wr && !pop)      count_d = count_q + CW'(1);
        else if (pop && !wr) count_d = count_q - CW'(1);
    end

    // NOTE: the storage array has no reset; only entries below count_q are ever read out.
    always_ff @(posedge CLK2) begin
        if (RST && wr) mem[wr_ptr_q] <= sr_q;
    end

    always_ff @(posedge CLK2) begin
        if (!RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            acc_q    <= 1'b0;
            a0_q     <= 1'b0;
            ovr_q    <= 1'b0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            int_q    <= 1'b1;
        end else begin
            acc_q   <= acc;
            count_q <= count_d;
            int_q   <= (count_d == '0);
            if (acc && !acc_q) a0_q <= A0;
            if (wr)  wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
            if (pop) rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
            // A set event in the clear cycle wins.
            ovr_q  <= ovr_set    | (ovr_q  & ~clr_req);
            perr_q <= perr_set_q | (perr_q & ~clr_req);
            ferr_q <= ferr_set_q | (ferr_q & ~clr_req);
        end
    end

    always_comb begin
        dout_mux = 8'h00;
        if (acc) begin
            if (A0)          dout_mux = status;
            else if (nempty) dout_mux = mem[rd_ptr_q];
        end
    end

    assign DOUT = dout_mux;
    assign DOE  = acc;
    assign INT  = int_q;

endmodule

// File: tb/tb_ps2_kb_fifo.sv
// Scoreboard bench for ps2_kb_fifo: PS/2 frames in, CPU reads out, checked against a queue model.
module tb_ps2_kb_fifo;

    localparam int DEPTH = 8;
`ifdef PS2_PARITY_DROP_EN
    localparam bit DROP_BAD = 1'b1;
`else
    localparam bit DROP_BAD = 1'b0;
`endif

    logic       CLK2 = 1'b0;
    logic       RST = 1'b0, KB_CLK = 1'b1, KB_DATA = 1'b1, CS = 1'b1, RD = 1'b1, A0 = 1'b0;
    logic [7:0] DOUT;
    logic       DOE, INT;

    ps2_kb_fifo #(.FIFO_AW(3), .FILTER_LEN(4), .TIMEOUT(2048)) dut (
        .CLK2(CLK2), .RST(RST), .KB_CLK(KB_CLK), .KB_DATA(KB_DATA),
        .CS(CS), .RD(RD), .A0(A0), .DOUT(DOUT), .DOE(DOE), .INT(INT)
    );

    always #5 CLK2 = ~CLK2;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] val;
        string      name;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [7:0] mq[$];
    logic       m_ovr = 1'b0, m_perr = 1'b0, m_ferr = 1'b0;
    logic       doe_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every new bus access pops one expected byte.
    always @(negedge CLK2) begin
        if (DOE && !doe_prev) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_read actual=0x%0h expected=none", DOUT);
            end else begin
                mon_e = exp_q.pop_front();
                check(mon_e.name, {24'h0, DOUT}, {24'h0, mon_e.val});
            end
        end
        doe_prev = DOE;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge CLK2);
    endtask

    function automatic logic [10:0] frame_bits(input logic [7:0] d, input logic par_bad,
                                               input logic stop);
        return {stop, (~^d) ^ par_bad, d, 1'b0};
    endfunction

    // rel > 0 ends the pending CPU access rel cycles into the stop bit's low phase.
    task automatic send_bits(input logic [10:0] bits, input int nbits, input int half,
                             input int rel);
        for (int i = 0; i < nbits; i++) begin
            KB_DATA = bits[i];
            idle(half);
            KB_CLK = 1'b0;
            for (int k = 1; k <= half; k++) begin
                @(negedge CLK2);
                if (i == 10 && k == rel) begin
                    RD = 1'b1;
                    CS = 1'b1;
                end
            end
            KB_CLK = 1'b1;
        end
        KB_DATA = 1'b1;
    endtask

    task automatic model_frame(input logic [7:0] d, input logic par_bad, input logic stop);
        if (!stop) begin
            m_ferr = 1'b1;
        end else begin
            if (par_bad) m_perr = 1'b1;
            if (!(par_bad && DROP_BAD)) begin
                if (mq.size() == DEPTH) m_ovr = 1'b1;
                else                    mq.push_back(d);
            end
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_bad, input logic stop,
                              input int half);
        send_bits(frame_bits(d, par_bad, stop), 11, half, 0);
        idle(12);
        model_frame(d, par_bad, stop);
    endtask

    function automatic exp_t expect_read(input logic a0, input string name);
        exp_t e;
        e.name = name;
        if (a0) begin
            e.val  = {3'b000, m_ferr, m_perr, m_ovr, mq.size() == DEPTH, mq.size() != 0};
            m_ovr  = 1'b0;
            m_perr = 1'b0;
            m_ferr = 1'b0;
        end else begin
            e.val = (mq.size() != 0) ? mq.pop_front() : 8'h00;
        end
        return e;
    endfunction

    task automatic cpu_read(input logic a0, input string name);
        exp_q.push_back(expect_read(a0, name));
        A0 = a0;
        CS = 1'b0;
        RD = 1'b0;
        idle(5);
        CS = 1'b1;
        RD = 1'b1;
        idle(6);
        check({name, "_seen"}, exp_q.size(), 0);
    endtask

    task automatic check_int(input string name);
        check(name, {31'h0, INT}, {31'h0, mq.size() == 0});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    logic [7:0] d;
    logic       pb, st;

    initial begin
        idle(4);
        check("reset_doe", {31'h0, DOE}, 0);
        check("reset_int", {31'h0, INT}, 1);
        check("reset_dout", {24'h0, DOUT}, 0);
        RST = 1'b1;
        idle(4);

        // Single frame at a 110-cycle bit period.
        send_frame(8'h1C, 1'b0, 1'b1, 55);
        check_int("t1_int_low");
        cpu_read(1'b1, "t1_status");
        cpu_read(1'b0, "t1_data");
        cpu_read(1'b1, "t1_status_empty");
        check_int("t1_int_high");

        // Overflow with nine frames into eight entries.
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b1, 20);
        cpu_read(1'b1, "t2_status_full_ovr");
        for (int i = 0; i < 8; i++) cpu_read(1'b0, $sformatf("t2_data%0d", i));
        cpu_read(1'b0, "t2_empty_read");
        cpu_read(1'b1, "t2_status_after");

        // Bad parity.
        send_frame(8'hF0, 1'b1, 1'b1, 20);
        cpu_read(1'b0, "t3_data");
        cpu_read(1'b1, "t3_status_perr");
        cpu_read(1'b1, "t3_status_cleared");

        // Truncated frame abandoned by timeout, then a good one.
        send_bits(frame_bits(8'hA5, 1'b0, 1'b1), 5, 20, 0);
        idle(3000);
        send_frame(8'h5A, 1'b0, 1'b1, 20);
        cpu_read(1'b1, "t4_status");
        cpu_read(1'b0, "t4_data");

        // Short KB_CLK glitches while idle, then a frame with a bad stop bit.
        KB_DATA = 1'b0;
        for (int i = 0; i < 3; i++) begin
            KB_CLK = 1'b0;
            idle(2);
            KB_CLK = 1'b1;
            idle(30);
        end
        KB_DATA = 1'b1;
        idle(20);
        cpu_read(1'b1, "t5_status_glitch");
        send_frame(8'h33, 1'b0, 1'b0, 20);
        cpu_read(1'b1, "t5_status_ferr");
        cpu_read(1'b1, "t5_status_cleared");
        check_int("t5_int");

        // Reset in the middle of a frame.
        send_frame(8'h11, 1'b0, 1'b1, 20);
        send_bits(frame_bits(8'h77, 1'b0, 1'b1), 6, 20, 0);
        RST = 1'b0;
        idle(2);
        RST = 1'b1;
        mq.delete();
        m_ovr = 1'b0;
        m_perr = 1'b0;
        m_ferr = 1'b0;
        idle(4);
        cpu_read(1'b1, "rst_status");
        check_int("rst_int");

        // Full FIFO: the data-read pop is aimed at the push cycle of a new frame.
        for (int i = 0; i < DEPTH; i++) send_frame(8'($urandom), 1'b0, 1'b1, 20);
        cpu_read(1'b1, "t6_status_full");
        d = 8'($urandom);
        exp_q.push_back(expect_read(1'b0, "t6_collide_data"));
        A0 = 1'b0;
        CS = 1'b0;
        RD = 1'b0;
        idle(4);
        send_bits(frame_bits(d, 1'b0, 1'b1), 11, 20, 5);
        idle(12);
        model_frame(d, 1'b0, 1'b1);
        check("t6_collide_seen", exp_q.size(), 0);
        cpu_read(1'b1, "t6_status_after");
        for (int i = 0; i < DEPTH; i++) cpu_read(1'b0, $sformatf("t6_drain%0d", i));
        check_int("t6_int");

        // Random frames with occasional bad parity / bad stop, interleaved reads.
        for (int i = 0; i < 20; i++) begin
            d  = 8'($urandom);
            pb = ($urandom_range(0, 3) == 0);
            st = ($urandom_range(0, 5) != 0);
            send_frame(d, pb, st, 20);
            if ($urandom_range(0, 2) == 0) cpu_read(1'b1, $sformatf("rnd_status%0d", i));
            else if ($urandom_range(0, 1) == 0) cpu_read(1'b0, $sformatf("rnd_data%0d", i));
        end
        while (mq.size() != 0) cpu_read(1'b0, "rnd_drain");
        cpu_read(1'b1, "rnd_final_status");
        check_int("rnd_final_int");

        check("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
